// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer driving an external 8-bit ALU.
// Define ALU_SEQUENCER_PERF_EN to build the retired-instruction counter.
module alu_sequencer #(
  parameter int PC_W            = 8,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [2:0]      alu_sel,
  input  logic [7:0]      alu_out,
  input  logic            alu_zero,
  output logic            zero_flag,
  output logic            halted,
  output logic            illegal,
  output logic [15:0]     retired_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_npc;
  logic [15:0]     r_ir;
  logic [7:0]      r_rf [4];
  logic [7:0]      r_a;
  logic [7:0]      r_b;
  logic [7:0]      r_res;
  logic [2:0]      r_sel;
  logic            r_req;
  logic            r_zf;
  logic            r_halted;
  logic            r_ill;

  logic [3:0]      w_op;
  logic [1:0]      w_rd;
  logic [1:0]      w_rs;
  logic [7:0]      w_imm;
  logic            w_alu;
  logic            w_ill;
  logic            w_stop;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_tgt;

  assign w_op     = r_ir[15:12];
  assign w_rd     = r_ir[11:10];
  assign w_rs     = r_ir[9:8];
  assign w_imm    = r_ir[7:0];
  assign w_alu    = (w_op <= 4'd5);
  assign w_ill    = (w_op >= 4'd9);
  assign w_stop   = (w_op == 4'd8) || (w_ill && HALT_ON_ILLEGAL);
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_tgt    = PC_W'(w_imm);

  // ALU operand regs load in DECODE so they are stable for all of EXECUTE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_npc    <= '0;
      r_ir     <= '0;
      for (int i = 0; i < 4; i++) r_rf[i] <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_sel    <= '0;
      r_req    <= 1'b0;
      r_zf     <= 1'b0;
      r_halted <= 1'b0;
      r_ill    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack) begin
            r_ir    <= imem_rdata;
            r_req   <= 1'b0;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a     <= r_rf[w_rd];
          r_b     <= (w_op == 4'd5) ? w_imm : r_rf[w_rs];
          r_sel   <= (w_op < 4'd5) ? w_op[2:0] : 3'd0;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_res <= alu_out;
          if (w_alu) r_zf <= alu_zero;
          if (w_ill) r_ill <= 1'b1;
          unique case (1'b1)
            (w_op == 4'd6): r_npc <= r_zf ? w_tgt : w_pc_inc;
            (w_op == 4'd7): r_npc <= w_tgt;
            w_stop:         r_npc <= r_pc;
            default:        r_npc <= w_pc_inc;
          endcase
          r_state <= S_WB;
        end
        S_WB: begin
          if (w_alu) r_rf[w_rd] <= r_res;
          r_pc <= r_npc;
          if (w_stop) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
          end
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_sel   = r_sel;
  assign zero_flag = r_zf;
  assign halted    = r_halted;
  assign illegal   = r_ill;

`ifdef ALU_SEQUENCER_PERF_EN
  logic [15:0] r_retired;

  always_ff @(posedge clk) begin
    if (!rst_n) r_retired <= '0;
    else if (r_state == S_WB) r_retired <= r_retired + 16'd1;
  end

  assign retired_cnt = r_retired;
`else
  assign retired_cnt = '0;
`endif

endmodule
